universal_shift_reg: RTL and testbench

UNIVERSAL_SHIFT_REG -- requirements
Module: universal_shift_reg

---
 rtl/universal_shift_reg.sv | 146 ++++++++++++++
 tb/tb_universal_shift_reg.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/universal_shift_reg.sv
// Universal shift register: parallel load plus counted bursts of shift/rotate
// operations, sequenced by a three-state IDLE/SHIFT/DONE controller.
module universal_shift_reg #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [CNT_W-1:0] count,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  state_t           state_r;
  state_t           state_next_s;
  logic [2:0]       mode_r;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] q_r;
  logic             sout_r;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] q_shift_s;
  logic             sout_shift_s;

  // Next-state decode; load has priority over start while idle
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (load) begin
          state_next_s = IDLE;
        end else if (start) begin
          if (count == {CNT_W{1'b0}}) begin
            state_next_s = DONE;
          end else begin
            state_next_s = SHIFT;
          end
        end else begin
          state_next_s = IDLE;
        end
      end
      SHIFT: begin
        if (cnt_r <= CNT_W'(1)) begin
          state_next_s = DONE;
        end else begin
          state_next_s = SHIFT;
        end
      end
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // One shift/rotate step of the captured mode; reserved modes hold
  always_comb begin
    q_shift_s    = q_r;
    sout_shift_s = sout_r;
    case (mode_r)
      3'b000: begin
        q_shift_s    = {q_r[WIDTH-2:0], sin};
        sout_shift_s = q_r[WIDTH-1];
      end
      3'b001: begin
        q_shift_s    = {sin, q_r[WIDTH-1:1]};
        sout_shift_s = q_r[0];
      end
      3'b010: begin
        q_shift_s    = {q_r[WIDTH-2:0], q_r[WIDTH-1]};
        sout_shift_s = q_r[WIDTH-1];
      end
      3'b011: begin
        q_shift_s    = {q_r[0], q_r[WIDTH-1:1]};
        sout_shift_s = q_r[0];
      end
      3'b100: begin
        q_shift_s    = {q_r[WIDTH-1], q_r[WIDTH-1:1]};
        sout_shift_s = q_r[0];
      end
      default: begin
        q_shift_s    = q_r;
        sout_shift_s = sout_r;
      end
    endcase
  end

  // Controller state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Datapath, burst bookkeeping and registered status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      q_r    <= {WIDTH{1'b0}};
      sout_r <= 1'b0;
      mode_r <= 3'b000;
      cnt_r  <= {CNT_W{1'b0}};
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= (state_next_s == SHIFT);
      done_r <= (state_next_s == DONE);
      case (state_r)
        IDLE: begin
          if (load) begin
            q_r <= d;
          end else if (start) begin
            mode_r <= mode;
            cnt_r  <= count;
          end
        end
        SHIFT: begin
          q_r    <= q_shift_s;
          sout_r <= sout_shift_s;
          cnt_r  <= cnt_r - CNT_W'(1);
        end
        default: begin
          q_r <= q_r;
        end
      endcase
    end
  end

  assign q    = q_r;
  assign sout = sout_r;
  assign busy = busy_r;
  assign done = done_r;

endmodule

// File: tb/tb_universal_shift_reg.sv
// Self-checking bench for universal_shift_reg: scoreboarded bursts against a
// bench-side shift model, plus directed reset, load/start and abort scenarios.
module tb_universal_shift_reg;

  logic       clk = 1'b0;
  logic       rst, load, start, sin;
  logic [7:0] d;
  logic [2:0] mode;
  logic [3:0] count;
  logic [7:0] q;
  logic       sout, busy, done;

  typedef struct packed {
    logic [7:0] q;
    logic       sout;
    logic [3:0] n;
  } exp_t;

  exp_t       sb[$];
  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] mq;
  logic       msout;

  universal_shift_reg #(.WIDTH(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .load(load), .d(d), .start(start), .mode(mode),
    .count(count), .sin(sin), .q(q), .sout(sout), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic void model_step(input logic [2:0] m, input logic s,
                                     input logic [7:0] qi, input logic si,
                                     output logic [7:0] qo, output logic so);
    qo = qi;
    so = si;
    case (m)
      3'd0: begin qo = {qi[6:0], s};     so = qi[7]; end
      3'd1: begin qo = {s, qi[7:1]};     so = qi[0]; end
      3'd2: begin qo = {qi[6:0], qi[7]}; so = qi[7]; end
      3'd3: begin qo = {qi[0], qi[7:1]}; so = qi[0]; end
      3'd4: begin qo = {qi[7], qi[7:1]}; so = qi[0]; end
      default: ;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; load = 1'b1; d = 8'hFF; start = 1'b1;
    mode = 3'd0; count = 4'd3; sin = 1'b1;
    tick();
    tick();
    n_vec++; if (q !== 8'h00) begin n_err++; $display("FAIL reset_q got %h want 00", q); end
    n_vec++; if (sout !== 1'b0) begin n_err++; $display("FAIL reset_sout got %b want 0", sout); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", done); end
    rst = 1'b0; load = 1'b0; start = 1'b0; sin = 1'b0;
    mq = 8'h00; msout = 1'b0;
  endtask

  task automatic do_load(input logic [7:0] v);
    load = 1'b1; d = v;
    tick();
    load = 1'b0;
    n_vec++; if (q !== v) begin n_err++; $display("FAIL load_q got %h want %h", q, v); end
    n_vec++; if (sout !== msout) begin n_err++; $display("FAIL load_sout got %b want %b", sout, msout); end
    mq = v;
  endtask

  // sin_sel: 0/1 hold sin constant, 2 drives a fresh random bit per shift
  task automatic run_burst(input logic [2:0] m, input int n, input bit disturb, input int sin_sel);
    logic       sins[16];
    logic [7:0] eq;
    logic       es;
    exp_t       e;
    int         bc;
    bit         seen;
    for (int i = 0; i < 16; i++) sins[i] = (sin_sel == 2) ? 1'($urandom_range(0, 1)) : sin_sel[0];
    eq = mq; es = msout;
    for (int i = 0; i < n; i++) model_step(m, sins[i], eq, es, eq, es);
    e.q = eq; e.sout = es; e.n = n[3:0];
    sb.push_back(e);

    start = 1'b1; mode = m; count = n[3:0]; sin = sins[0];
    tick();
    start = 1'b0;
    bc = 0; seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      if (done === 1'b1) begin
        seen = 1'b1;
      end else begin
        if (busy === 1'b1) begin
          sin = sins[bc % 16];
          bc++;
        end
        if (disturb) begin
          load = 1'b1; start = 1'b1; d = 8'($urandom);
          mode = 3'($urandom); count = 4'($urandom);
        end
        tick();
      end
    end
    e = sb.pop_front();
    n_vec++; if (!seen) begin n_err++; $display("FAIL burst_timeout mode %0d got no done want done", m); end
    n_vec++; if (q !== e.q) begin n_err++; $display("FAIL burst_q mode %0d got %h want %h", m, q, e.q); end
    n_vec++; if (sout !== e.sout) begin n_err++; $display("FAIL burst_sout mode %0d got %b want %b", m, sout, e.sout); end
    n_vec++; if (bc != int'(e.n)) begin n_err++; $display("FAIL burst_busy_cycles mode %0d got %0d want %0d", m, bc, e.n); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL burst_busy_at_done got %b want 0", busy); end
    tick();
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL done_width got %b want 0", done); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL idle_busy got %b want 0", busy); end
    n_vec++; if (q !== e.q) begin n_err++; $display("FAIL done_hold_q got %h want %h", q, e.q); end
    load = 1'b0; start = 1'b0;
    mq = e.q; msout = e.sout;
  endtask

  task automatic test_rotate_left();
    do_load(8'hA5);
    run_burst(3'd2, 3, 1'b0, 0);
    n_vec++; if (q !== 8'h2D) begin n_err++; $display("FAIL rol_q got %h want 2d", q); end
    n_vec++; if (sout !== 1'b1) begin n_err++; $display("FAIL rol_sout got %b want 1", sout); end
  endtask

  task automatic test_arith_right();
    do_load(8'h90);
    run_burst(3'd4, 2, 1'b0, 0);
    n_vec++; if (q !== 8'hE4) begin n_err++; $display("FAIL asr_q got %h want e4", q); end
    n_vec++; if (sout !== 1'b0) begin n_err++; $display("FAIL asr_sout got %b want 0", sout); end
  endtask

  task automatic test_shift_left();
    do_load(8'hF0);
    run_burst(3'd0, 3, 1'b0, 1);
    n_vec++; if (q !== 8'h87) begin n_err++; $display("FAIL shl_q got %h want 87", q); end
    n_vec++; if (sout !== 1'b1) begin n_err++; $display("FAIL shl_sout got %b want 1", sout); end
  endtask

  task automatic test_zero_count();
    do_load(8'h5A);
    run_burst(3'd1, 0, 1'b0, 2);
    n_vec++; if (q !== 8'h5A) begin n_err++; $display("FAIL zero_q got %h want 5a", q); end
  endtask

  task automatic test_all_modes();
    for (int m = 0; m < 8; m++) begin
      do_load(8'($urandom));
      run_burst(3'(m), $urandom_range(1, 15), (m % 2) == 1, 2);
    end
  endtask

  task automatic test_load_start();
    load = 1'b1; start = 1'b1; d = 8'h3C; mode = 3'd0; count = 4'd5;
    tick();
    load = 1'b0; start = 1'b0;
    n_vec++; if (q !== 8'h3C) begin n_err++; $display("FAIL ldst_q got %h want 3c", q); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL ldst_busy got %b want 0", busy); end
    tick();
    n_vec++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL ldst_noburst got busy %b done %b want 0 0", busy, done); end
    n_vec++; if (q !== 8'h3C) begin n_err++; $display("FAIL ldst_hold got %h want 3c", q); end
    mq = 8'h3C;
  endtask

  task automatic test_reset_abort();
    do_load(8'h5A);
    start = 1'b1; mode = 3'd0; count = 4'd5; sin = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL abort_midburst_busy got %b want 1", busy); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_vec++; if (q !== 8'h00) begin n_err++; $display("FAIL abort_q got %h want 00", q); end
    n_vec++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL abort_flags got busy %b done %b want 0 0", busy, done); end
    n_vec++; if (sout !== 1'b0) begin n_err++; $display("FAIL abort_sout got %b want 0", sout); end
    mq = 8'h00; msout = 1'b0;
    load = 1'b1; d = 8'h77;
    tick();
    load = 1'b0;
    n_vec++; if (q !== 8'h77) begin n_err++; $display("FAIL post_rst_load got %h want 77", q); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL abort_no_done got %b want 0", done); end
    tick();
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL abort_no_done2 got %b want 0", done); end
    mq = 8'h77;
  endtask

  task automatic test_back_to_back();
    run_burst(3'd3, 4, 1'b0, 2);
    run_burst(3'd1, 7, 1'b1, 2);
    run_burst(3'd0, 0, 1'b0, 2);
    run_burst(3'd2, 15, 1'b0, 2);
  endtask

  initial begin
    test_reset();
    test_rotate_left();
    test_arith_right();
    test_shift_left();
    test_zero_count();
    test_all_modes();
    test_load_start();
    test_reset_abort();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
